// File: rtl/biriscv_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr, fault}
// with a fault hold that blocks further fetches until the next redirect.
module biriscv_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               fetch_valid_i,
    input  logic [31:0]        fetch_pc_i,
    input  logic [31:0]        fetch_instr_i,
    input  logic               fetch_fault_i,
    output logic               fetch_accept_o,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        opcode_o,
    output logic               fetch_fault_o,
    input  logic               accept_i,
    output logic [DEPTH_W:0]   level_o,
    output logic               fault_hold_o
);

    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_HOLD = 1'b1;
    localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W + 1)'(DEPTH);

    logic [31:0]        pc_q    [DEPTH];
    logic [31:0]        instr_q [DEPTH];
    logic               fault_q [DEPTH];

    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]   count_q,  count_d;
    logic               state_q,  state_d;

    logic               full;
    logic               push;
    logic               pop;

    always_comb begin
        full           = (count_q == DEPTH_L);
        fetch_accept_o = !full && (state_q != STATE_HOLD) && !flush_i;
        valid_o        = (count_q != '0);
        push           = fetch_valid_i && fetch_accept_o;
        pop            = valid_o && accept_i && !flush_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        // Flush wins over any same-cycle push or pop
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = STATE_RUN;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_W'(1);
            if (push && !pop)
                count_d = count_q + (DEPTH_W + 1)'(1);
            else if (pop && !push)
                count_d = count_q - (DEPTH_W + 1)'(1);
            if (push && fetch_fault_i)
                state_d = STATE_HOLD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= STATE_RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // Entry storage is deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_q[wr_ptr_q]    <= fetch_pc_i;
            instr_q[wr_ptr_q] <= fetch_instr_i;
            fault_q[wr_ptr_q] <= fetch_fault_i;
        end
    end

    assign pc_o          = pc_q[rd_ptr_q];
    assign opcode_o      = instr_q[rd_ptr_q];
    assign fetch_fault_o = fault_q[rd_ptr_q];
    assign level_o       = count_q;
    assign fault_hold_o  = (state_q == STATE_HOLD);

endmodule
